// File: rtl/fsm_sequence_monitor_if.sv
// fsm_sequence_monitor_if: observed-state bus and monitor result signals
interface fsm_sequence_monitor_if #(
  parameter int STATE_W = 4,
  parameter int CNT_W = 8
);
  logic [STATE_W-1:0] state_in;
  logic state_vld;
  logic clear;
  logic done;
  logic error;
  logic [1:0] err_code;
  logic [STATE_W-1:0] err_state;
  logic [STATE_W-1:0] exp_state;
  logic [CNT_W-1:0] trans_cnt;
  logic [CNT_W-1:0] err_cnt;
  modport master (
    output state_in, state_vld, clear,
    input done, error, err_code, err_state, exp_state, trans_cnt, err_cnt
  );
  modport slave (
    input state_in, state_vld, clear,
    output done, error, err_code, err_state, exp_state, trans_cnt, err_cnt
  );
endinterface

// File: rtl/fsm_sequence_monitor.sv
// fsm_sequence_monitor: passive order checker for a stepping FSM state bus
module fsm_sequence_monitor #(
  parameter int STATE_W = 4,
  parameter int LAST_STATE = 6,
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input logic aclk,
  input logic aresetn,
  fsm_sequence_monitor_if.slave mon
);
  localparam int SW = $clog2(TIMEOUT);
  localparam logic [STATE_W-1:0] LAST = STATE_W'(LAST_STATE);
  typedef enum logic [1:0] {WAIT_START, TRACK, COMPLETE} mode_t;
  mode_t mode_q, mode_d;
  logic [STATE_W-1:0] cur_q, cur_d, exp_q, exp_d, err_state_q, err_state_d, estate;
  logic [SW-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] trans_cnt_q, trans_cnt_d, err_cnt_q, err_cnt_d;
  logic [1:0] err_code_q, err_code_d, ecode;
  logic done_q, done_d, error_q, error_d;
  logic accept, illegal;
  assign accept = mon.state_vld && mon.state_in == exp_q;
  assign illegal = mon.state_vld && !accept && mon.state_in != cur_q;
  always_comb begin
    mode_d = mode_q;
    cur_d = cur_q;
    exp_d = exp_q;
    stall_d = stall_q;
    trans_cnt_d = trans_cnt_q;
    err_cnt_d = err_cnt_q;
    err_code_d = err_code_q;
    err_state_d = err_state_q;
    done_d = done_q;
    error_d = 1'b0;
    ecode = 2'd0;
    estate = mon.state_in;
    if (mon.clear) begin
      mode_d = WAIT_START;
      cur_d = '0;
      exp_d = '0;
      stall_d = '0;
      trans_cnt_d = '0;
      err_cnt_d = '0;
      err_code_d = '0;
      err_state_d = '0;
      done_d = 1'b0;
    end else if (mode_q == WAIT_START && mon.state_vld) begin
      if (mon.state_in == '0) begin
        mode_d = TRACK;
        cur_d = '0;
        exp_d = STATE_W'(1);
        stall_d = '0;
      end else ecode = 2'd1;
    end else if (mode_q == TRACK) begin
      if (accept) begin
        trans_cnt_d = (&trans_cnt_q) ? trans_cnt_q : trans_cnt_q + CNT_W'(1);
        cur_d = mon.state_in;
        exp_d = mon.state_in == LAST ? '0 : mon.state_in + STATE_W'(1);
        mode_d = mon.state_in == LAST ? COMPLETE : TRACK;
        done_d = mon.state_in == LAST;
        stall_d = '0;
      end else if (illegal) begin
        ecode = 2'd2;
        stall_d = '0;
        if (mon.state_in <= LAST) begin
          cur_d = mon.state_in;
          exp_d = mon.state_in + STATE_W'(1);
          mode_d = mon.state_in == LAST ? COMPLETE : TRACK;
        end else begin
          mode_d = WAIT_START;
          exp_d = '0;
        end
      end else if (stall_q == SW'(TIMEOUT - 1)) begin
        ecode = 2'd3;
        estate = exp_q;
        mode_d = WAIT_START;
        exp_d = '0;
        stall_d = '0;
      end else stall_d = stall_q + SW'(1);
    end
    if (ecode != 2'd0) begin
      error_d = 1'b1;
      err_code_d = ecode;
      err_state_d = estate;
      err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q <= WAIT_START;
      cur_q <= '0;
      exp_q <= '0;
      stall_q <= '0;
      trans_cnt_q <= '0;
      err_cnt_q <= '0;
      err_code_q <= '0;
      err_state_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cur_q <= cur_d;
      exp_q <= exp_d;
      stall_q <= stall_d;
      trans_cnt_q <= trans_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_code_q <= err_code_d;
      err_state_q <= err_state_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
  assign mon.done = done_q;
  assign mon.error = error_q;
  assign mon.err_code = err_code_q;
  assign mon.err_state = err_state_q;
  assign mon.exp_state = exp_q;
  assign mon.trans_cnt = trans_cnt_q;
  assign mon.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_fsm_sequence_monitor.sv
// tb_fsm_sequence_monitor: directed and random stimulus against a rule-level reference model
module tb_fsm_sequence_monitor;
  localparam int STATE_W = 4;
  localparam int LAST = 6;
  localparam int TIMEOUT = 16;
  localparam int CNT_W = 8;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int m_mode, m_cur, m_exp, m_idle, m_tc, m_ec, m_code, m_est;
  bit m_done, m_err;
  fsm_sequence_monitor_if #(.STATE_W(STATE_W), .CNT_W(CNT_W)) ifc ();
  fsm_sequence_monitor #(.STATE_W(STATE_W), .LAST_STATE(LAST), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W))
    dut (.aclk(aclk), .aresetn(aresetn), .mon(ifc.slave));
  always #5 aclk = ~aclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_exp = 0; m_idle = 0; m_tc = 0; m_ec = 0;
    m_code = 0; m_est = 0; m_done = 0; m_err = 0;
  endtask
  task automatic flag(input int code, input int st);
    m_err = 1; m_code = code; m_est = st;
    m_ec = (m_ec == CMAX) ? CMAX : m_ec + 1;
  endtask
  // m_mode: 0 waiting for a zero, 1 following the sequence, 2 finished
  task automatic model(input bit v, input int s, input bit c);
    m_err = 0;
    if (c) model_reset();
    else if (m_mode == 0) begin
      if (v && s == 0) begin m_mode = 1; m_cur = 0; m_exp = 1; m_idle = 0; end
      else if (v) flag(1, s);
    end else if (m_mode == 1) begin
      if (v && s == m_exp) begin
        m_tc = (m_tc == CMAX) ? CMAX : m_tc + 1;
        m_cur = s; m_idle = 0;
        m_exp = (s == LAST) ? 0 : s + 1;
        if (s == LAST) begin m_mode = 2; m_done = 1; end
      end else if (v && s != m_cur) begin
        flag(2, s);
        m_idle = 0;
        if (s <= LAST) begin m_cur = s; m_exp = s + 1; m_mode = (s == LAST) ? 2 : 1; end
        else begin m_mode = 0; m_exp = 0; end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin flag(3, m_exp); m_mode = 0; m_exp = 0; end
      end
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".error"}, ifc.error, m_err);
    check({tag, ".done"}, ifc.done, m_done);
    check({tag, ".err_code"}, ifc.err_code, m_code);
    check({tag, ".err_state"}, ifc.err_state, m_est);
    check({tag, ".exp_state"}, ifc.exp_state, m_exp);
    check({tag, ".trans_cnt"}, ifc.trans_cnt, m_tc);
    check({tag, ".err_cnt"}, ifc.err_cnt, m_ec);
  endtask
  task automatic step(input bit v, input int s, input bit c, input string tag);
    ifc.state_vld = v;
    ifc.state_in = STATE_W'(s);
    ifc.clear = c;
    @(posedge aclk);
    model(v, s, c);
    #1;
    check_all(tag);
  endtask
  task automatic seq(input int n, input string tag);
    for (int i = 0; i <= n; i++) step(1, i, 0, tag);
  endtask
  task automatic do_clear();
    step(0, 0, 1, "clear");
  endtask
  initial begin
    int s, r;
    bit v, c;
    ifc.state_vld = 0; ifc.state_in = '0; ifc.clear = 0;
    model_reset();
    #2 aresetn = 1'b0;
    #1;
    check_all("reset");
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    seq(LAST, "full");
    check("full.done", ifc.done, 1);
    check("full.trans", ifc.trans_cnt, 6);
    check("full.errcnt", ifc.err_cnt, 0);
    step(1, 3, 0, "complete_ignores");
    step(1, 0, 1, "clear_with_sample");
    check("clr.done", ifc.done, 0);
    check("clr.trans", ifc.trans_cnt, 0);
    step(1, 3, 0, "bad_start");
    check("bs.error", ifc.error, 1);
    check("bs.code", ifc.err_code, 1);
    check("bs.state", ifc.err_state, 3);
    seq(LAST, "after_bs");
    check("bs.done", ifc.done, 1);
    check("bs.trans", ifc.trans_cnt, 6);
    do_clear();
    seq(2, "ill");
    step(1, 5, 0, "ill5");
    check("ill.code", ifc.err_code, 2);
    check("ill.state", ifc.err_state, 5);
    check("ill.exp", ifc.exp_state, 6);
    step(1, 6, 0, "ill_then6");
    do_clear();
    seq(2, "ill_last");
    step(1, 6, 0, "ill_last6");
    check("il.done", ifc.done, 0);
    check("il.trans", ifc.trans_cnt, 2);
    check("il.code", ifc.err_code, 2);
    step(1, 4, 0, "il_complete_ignores");
    do_clear();
    seq(1, "to");
    for (int i = 1; i <= TIMEOUT; i++) step(0, 0, 0, "to_idle");
    check("to.error", ifc.error, 1);
    check("to.code", ifc.err_code, 3);
    check("to.state", ifc.err_state, 2);
    check("to.exp", ifc.exp_state, 0);
    step(1, 5, 0, "to_waitstart");
    check("to.ws_code", ifc.err_code, 1);
    do_clear();
    seq(1, "to_var");
    for (int i = 1; i < TIMEOUT - 1; i++) step(i % 3 == 0, 1, 0, "to_var_idle");
    step(1, 2, 0, "to_var_accept");
    check("tv.error", ifc.error, 0);
    check("tv.trans", ifc.trans_cnt, 2);
    check("tv.errcnt", ifc.err_cnt, 0);
    do_clear();
    step(1, 0, 0, "sat_start");
    for (int k = 0; k < 130; k++) begin
      for (int i = 1; i < LAST; i++) step(1, i, 0, "sat_run");
      step(1, 15, 0, "sat_ill");
      step(1, 3, 0, "sat_bs");
      step(1, 0, 0, "sat_restart");
    end
    check("sat.trans", ifc.trans_cnt, CMAX);
    check("sat.err", ifc.err_cnt, CMAX);
    step(1, 9, 0, "sat_pulse");
    check("sat.pulse", ifc.error, 1);
    check("sat.err_hold", ifc.err_cnt, CMAX);
    do_clear();
    seq(3, "async");
    #2 aresetn = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async.trans", ifc.trans_cnt, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      v = $urandom_range(0, 3) != 0;
      c = (m_mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 127) == 0);
      s = (r < 6) ? m_exp : (r < 8) ? m_cur : $urandom_range(0, 15);
      step(v, s, c, "rand");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
